// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS datapath slice.
//   - primary opcode values seen by the control unit
//   - NOP/bubble instruction word
//   - fetch FSM state encoding
//   - default reset PC and a word-alignment helper
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  // Bubble word: decodes as sll $0,$0,0, harmless to the control unit.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_i      load a bubble (NOP, valid=0); wins over load_i
//   load_i       capture instr_i/pc4_i as a valid instruction
//   instr_i/pc4_i  incoming instruction word and its PC+4
//   instr_o/pc4_o/valid_o  registered contents; hold when neither control set
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_o <= NOP_INSTR;
      pc4_o   <= '0;
      valid_o <= 1'b0;
    end else if (flush_i) begin
      instr_o <= NOP_INSTR;
      pc4_o   <= '0;
      valid_o <= 1'b0;
    end else if (load_i) begin
      instr_o <= instr_i;
      pc4_o   <= pc4_i;
      valid_o <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage (PC, imem handshake, redirects,
// IF/ID register).
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem_req/imem_addr           word fetch request to instruction memory
//   imem_ready/imem_rdata        memory response for the current request
//   stall                        decode cannot accept; IF/ID holds
//   branch_taken/branch_target   redirect (lower priority)
//   jump/jump_target             redirect (higher priority)
//   if_id_instr/if_id_pc4/if_id_valid  IF/ID register contents
//   opcode                       if_id_instr[31:26] to the control unit
//   fetch_cnt/stall_cnt          saturating perf counters, only when
//                                FETCH_PERF_CNT_EN is defined
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic [31:0]  skid_q, skid_d;

  logic         redirect;
  logic [31:0]  redir_tgt;
  logic [31:0]  pc4;
  logic         ifid_flush, ifid_load;
  logic [31:0]  ifid_instr_in;

  assign redirect  = jump | branch_taken;
  assign redir_tgt = word_align(jump ? jump_target : branch_target);
  assign pc4       = pc_q + 32'd4;
  assign imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      skid_q     <= skid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
    skid_d        = skid_q;
    imem_req      = 1'b0;
    ifid_flush    = 1'b0;
    ifid_load     = 1'b0;
    ifid_instr_in = imem_rdata;
    case (state_q)
      S_BOOT: begin
        state_d    = S_FETCH;
        ifid_flush = redirect;
        if (redirect) pc_d = redir_tgt;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (redirect || pend_q) begin
            // A redirect seen this cycle is newer than a pending one.
            pc_d   = redirect ? redir_tgt : pend_tgt_q;
            pend_d = 1'b0;
          end else if (stall) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc4;
          end
        end else if (redirect) begin
          // Address must stay stable until the outstanding request completes.
          pend_d     = 1'b1;
          pend_tgt_d = redir_tgt;
        end
        // Redirect beats stall; otherwise a cycle without a new word is a bubble.
        ifid_flush = redirect || (!stall && !ifid_load);
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d       = redir_tgt;
          skid_d     = NOP_INSTR;
          ifid_flush = 1'b1;
          state_d    = S_FETCH;
        end else if (!stall) begin
          // pc still points at the skid word, so pc+4 is its link value.
          ifid_load     = 1'b1;
          ifid_instr_in = skid_q;
          pc_d          = pc4;
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (ifid_flush),
    .load_i  (ifid_load),
    .instr_i (ifid_instr_in),
    .pc4_i   (pc4),
    .instr_o (if_id_instr),
    .pc4_o   (if_id_pc4),
    .valid_o (if_id_valid)
  );

  assign opcode = if_id_instr[31:26];

`ifdef FETCH_PERF_CNT_EN
  logic        accept;
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Words captured into the skid count here, not again when delivered.
  assign accept = (state_q == S_FETCH) && imem_ready && !redirect && !pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
// Expected fetch addresses and consumed IF/ID entries are queued by the
// stimulus; a negedge monitor pops and compares on each memory handshake
// (imem_req && imem_ready) and each instruction taken by decode
// (if_id_valid && !stall).
module tb_fetch_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .opcode        (opcode)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_ins[$];

  logic        fixed_en;
  logic [31:0] fixed_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory contents: distinct word per address; low addresses decode as lw.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h8C08_0004 ^ a;
  endfunction

  task automatic cyc();
    imem_rdata = fixed_en ? fixed_word : memw(imem_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic push_i(input logic [31:0] ins, input logic [31:0] pc4);
    exp_ins.push_back({ins, pc4});
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] ea;
    logic [63:0] ei;
    if (imem_req && imem_ready) begin
      if (exp_addr.size() == 0) begin
        n_checks++;
        $display("FAIL addr_extra: got %h expected none", imem_addr);
      end else begin
        ea = exp_addr.pop_front();
        chk("imem_addr", 64'(imem_addr), 64'(ea));
      end
    end
    if (if_id_valid && !stall) begin
      if (exp_ins.size() == 0) begin
        n_checks++;
        $display("FAIL ifid_extra: got %h/%h expected none", if_id_instr, if_id_pc4);
      end else begin
        ei = exp_ins.pop_front();
        chk("if_id_instr_pc4", {if_id_instr, if_id_pc4}, ei);
        chk("opcode", 64'(opcode), 64'(ei[63:58]));
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    rst_n = 1'b1; imem_ready = 1'b1; stall = 1'b0; imem_rdata = '0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
    fixed_en = 1'b0; fixed_word = '0;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req",    64'(imem_req),    64'(0));
    chk("rst_addr",   64'(imem_addr),   64'(0));
    chk("rst_valid",  64'(if_id_valid), 64'(0));
    chk("rst_instr",  64'(if_id_instr), 64'(0));
    chk("rst_pc4",    64'(if_id_pc4),   64'(0));
    chk("rst_opcode", 64'(opcode),      64'(0));

    // Streaming fetch after reset release.
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8); exp_addr.push_back(32'hC);
    push_i(memw(32'h0), 32'h4); push_i(memw(32'h4), 32'h8);
    rst_n = 1'b1;
    chk("boot_req", 64'(imem_req), 64'(0));
    cyc();
    chk("first_req",   64'(imem_req),    64'(1));
    chk("first_nodat", 64'(if_id_valid), 64'(0));
    cyc();
    chk("first_valid",  64'(if_id_valid), 64'(1));
    chk("first_opcode", 64'(opcode),      64'(6'b100011));
    chk("first_pc4",    64'(if_id_pc4),   64'(4));
    cyc(); cyc();

    // Stall across the return of addi at pc 0xC.
    fixed_en = 1'b1; fixed_word = 32'h2008_0005; stall = 1'b1;
    push_i(memw(32'h8), 32'hC); push_i(32'h2008_0005, 32'h10);
    cyc();
    chk("hold_req", 64'(imem_req), 64'(0));
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold_instr",  64'(if_id_instr), 64'(memw(32'h8)));
      chk("stall_hold_opcode", 64'(opcode),      64'(6'b100011));
      if (i < 2) cyc();
    end
    stall = 1'b0;
    cyc();
    fixed_en = 1'b0;
    chk("skid_instr",  64'(if_id_instr), 64'(32'h2008_0005));
    chk("skid_opcode", 64'(opcode),      64'(6'b001000));
    chk("skid_pc4",    64'(if_id_pc4),   64'(32'h10));
    chk("skid_addr",   64'(imem_addr),   64'(32'h10));

    // Branch with the word arriving in the same cycle; low target bits dropped.
    branch_taken = 1'b1; branch_target = 32'h43;
    exp_addr.push_back(32'h10); exp_addr.push_back(32'h40); exp_addr.push_back(32'h44);
    push_i(memw(32'h40), 32'h44);
    cyc();
    branch_taken = 1'b0;
    chk("br_valid", 64'(if_id_valid), 64'(0));
    chk("br_instr", 64'(if_id_instr), 64'(0));
    chk("br_addr",  64'(imem_addr),   64'(32'h40));
    cyc();
    chk("br_refill_valid", 64'(if_id_valid), 64'(1));
    chk("br_refill_pc4",   64'(if_id_pc4),   64'(32'h44));

    // Jump and branch together: jump wins.
    jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h40;
    exp_addr.push_back(32'h100);
    push_i(memw(32'h100), 32'h104);
    cyc();
    jump = 1'b0; branch_taken = 1'b0;
    chk("jb_addr",  64'(imem_addr),   64'(32'h100));
    chk("jb_valid", 64'(if_id_valid), 64'(0));
    cyc();

    // Slow memory: jump arrives while the request at 0x104 is outstanding.
    imem_ready = 1'b0;
    exp_addr.push_back(32'h104); exp_addr.push_back(32'h200);
    push_i(memw(32'h200), 32'h204);
    cyc();
    chk("wait_addr",  64'(imem_addr),   64'(32'h104));
    chk("wait_req",   64'(imem_req),    64'(1));
    chk("wait_valid", 64'(if_id_valid), 64'(0));
    jump = 1'b1; jump_target = 32'h200;
    cyc();
    jump = 1'b0;
    cyc(); cyc();
    chk("wait_addr_stable", 64'(imem_addr), 64'(32'h104));
    imem_ready = 1'b1;
    cyc();
    chk("pend_addr",  64'(imem_addr),   64'(32'h200));
    chk("pend_valid", 64'(if_id_valid), 64'(0));
    cyc();

    // PC+4 wrap at the top of the address space.
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    exp_addr.push_back(32'h204); exp_addr.push_back(32'hFFFF_FFFC); exp_addr.push_back(32'h0);
    push_i(memw(32'hFFFF_FFFC), 32'h0);
    cyc();
    jump = 1'b0;
    chk("wrap_target", 64'(imem_addr), 64'(32'hFFFF_FFFC));
    cyc();
    chk("wrap_pc4",   64'(if_id_pc4),   64'(0));
    chk("wrap_valid", 64'(if_id_valid), 64'(1));
    chk("wrap_addr",  64'(imem_addr),   64'(0));
    cyc();

    // Asynchronous reset while a request is outstanding and IF/ID is held.
    imem_ready = 1'b0; stall = 1'b1;
    cyc();
    chk("pre_rst_valid", 64'(if_id_valid), 64'(1));
    chk("pre_rst_addr",  64'(imem_addr),   64'(4));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   64'(imem_req),    64'(0));
    chk("arst_addr",  64'(imem_addr),   64'(0));
    chk("arst_valid", 64'(if_id_valid), 64'(0));
    chk("arst_instr", 64'(if_id_instr), 64'(0));
    chk("arst_pc4",   64'(if_id_pc4),   64'(0));
    imem_ready = 1'b1;
    @(posedge clk); #1;
    chk("arst_ignore_resp", 64'(if_id_valid), 64'(0));
    stall = 1'b0;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
    push_i(memw(32'h0), 32'h4); push_i(memw(32'h4), 32'h8);
    rst_n = 1'b1;
    cyc(); cyc();
    chk("rerun_valid", 64'(if_id_valid), 64'(1));
    chk("rerun_pc4",   64'(if_id_pc4),   64'(4));
    cyc();
    imem_ready = 1'b0;
    cyc(); cyc();

    chk("addr_queue_left", 64'(exp_addr.size()), 64'(0));
    chk("ins_queue_left",  64'(exp_ins.size()),  64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
